// File: rtl/atom_mem_arbiter.sv
// atom_mem_arbiter: shares the single-port 192 KB ROM/RAM between the Atom
// CPU bus and the HPS ioctl download path. The download path fills ROM slot 7.
// CPU accesses win by default. A starvation counter forces a pending download
// byte through after STARVE_MAX CPU slots. CPU writes aimed at ROM are dropped.
module atom_mem_arbiter #(
  parameter logic [7:0]  DL_INDEX   = 8'd1,
  parameter logic [17:0] DL_BASE    = 18'h17000,
  parameter int          DL_SIZE    = 4096,
  parameter int          STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [17:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_rom,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        dl_active,
  output logic        dl_done,
  output logic [12:0] dl_count,
  output logic [17:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CPU_ADDR = 2'd1;
  localparam logic [1:0] S_CPU_DATA = 2'd2;
  localparam logic [1:0] S_DL_WR    = 2'd3;

  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [12:0] DL_SIZE_C  = 13'(DL_SIZE);
  localparam logic [24:0] DL_SIZE_A  = 25'(DL_SIZE);

  logic [1:0]    r_state;
  logic [SW-1:0] r_starve;
  logic          r_busy;       // CPU request latched and not yet acknowledged
  logic          r_pend;       // latched CPU request not yet started
  logic [17:0]   r_cpu_addr;
  logic          r_cpu_we;
  logic          r_cpu_rom;
  logic [7:0]    r_cpu_wdata;
  logic          r_hold_full;
  logic [17:0]   r_hold_addr;
  logic [7:0]    r_hold_data;
  logic          r_done_wait;  // accept dropped while a byte was still held
  logic [7:0]    r_cpu_rdata;
  logic          r_cpu_ready;
  logic          r_dl_active;
  logic          r_dl_done;
  logic [12:0]   r_dl_count;
  logic [17:0]   r_mem_addr;
  logic          r_mem_we;
  logic [7:0]    r_mem_din;

  logic          w_accept;
  logic          w_dl_load;
  logic          w_new_req;
  logic          w_cpu_want;
  logic          w_forced;
  logic          w_go_cpu;
  logic          w_go_dl;
  logic          w_acc_rise;
  logic          w_acc_fall;
  logic [17:0]   w_req_addr;
  logic          w_req_we;
  logic          w_req_rom;
  logic [7:0]    w_req_wdata;

  assign w_accept   = ioctl_download && (ioctl_index == DL_INDEX);
  assign w_dl_load  = ioctl_wr && w_accept && (ioctl_addr < DL_SIZE_A) && !r_hold_full;
  assign w_new_req  = cpu_req && !r_busy;
  assign w_cpu_want = w_new_req || r_pend;
  assign w_forced   = r_hold_full && (r_starve == STARVE_LIM);
  assign w_acc_rise = w_accept && !r_dl_active;
  assign w_acc_fall = r_dl_active && !w_accept;

  // A request arriving this cycle is used directly so an idle access starts at once.
  assign w_req_addr  = w_new_req ? cpu_addr  : r_cpu_addr;
  assign w_req_we    = w_new_req ? cpu_we    : r_cpu_we;
  assign w_req_rom   = w_new_req ? cpu_rom   : r_cpu_rom;
  assign w_req_wdata = w_new_req ? cpu_wdata : r_cpu_wdata;

  // The download slot hands straight over to a waiting CPU access, which keeps a
  // colliding request within one extra cycle of the normal latency.
  assign w_go_cpu = w_cpu_want &&
                    (((r_state == S_IDLE) && !w_forced) || (r_state == S_DL_WR));
  assign w_go_dl  = (r_state == S_IDLE) && r_hold_full && (w_forced || !w_cpu_want);

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ready  = r_cpu_ready;
  assign ioctl_wait = r_hold_full;
  assign dl_active  = r_dl_active;
  assign dl_done    = r_dl_done;
  assign dl_count   = r_dl_count;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_din    = r_mem_din;

  // Arbitration FSM, holding register, registered memory port and download status.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_we    <= 1'b0;
      r_cpu_rom   <= 1'b0;
      r_cpu_wdata <= '0;
      r_hold_full <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_done_wait <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_dl_active <= 1'b0;
      r_dl_done   <= 1'b0;
      r_dl_count  <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dl_done   <= 1'b0;
      r_dl_active <= w_accept;

      if (w_new_req) begin
        r_busy      <= 1'b1;
        r_cpu_addr  <= cpu_addr;
        r_cpu_we    <= cpu_we;
        r_cpu_rom   <= cpu_rom;
        r_cpu_wdata <= cpu_wdata;
      end

      if (w_dl_load) begin
        r_hold_full <= 1'b1;
        r_hold_addr <= DL_BASE + {6'd0, ioctl_addr[11:0]};
        r_hold_data <= ioctl_dout;
      end

      case (r_state)
        S_IDLE: begin
          if (w_go_dl) begin
            r_state <= S_DL_WR;
            r_pend  <= w_cpu_want;
          end
        end
        S_CPU_ADDR: begin
          if (r_hold_full && (r_starve != STARVE_LIM))
            r_starve <= r_starve + SW'(1);
          r_state <= S_CPU_DATA;
        end
        S_CPU_DATA: begin
          r_cpu_rdata <= mem_dout;
          r_cpu_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_hold_full <= 1'b0;
          r_starve    <= '0;
          if (r_dl_count != DL_SIZE_C)
            r_dl_count <= r_dl_count + 13'd1;
          if (!w_go_cpu)
            r_state <= S_IDLE;
        end
      endcase

      if (w_go_cpu) begin
        r_state    <= S_CPU_ADDR;
        r_pend     <= 1'b0;
        r_mem_addr <= w_req_addr;
        r_mem_din  <= w_req_wdata;
        r_mem_we   <= w_req_we && !w_req_rom;
      end else if (w_go_dl) begin
        r_mem_addr <= r_hold_addr;
        r_mem_din  <= r_hold_data;
        r_mem_we   <= 1'b1;
      end

      if (w_acc_rise)
        r_dl_count <= '0;

      // End-of-download pulse is held back until the last byte has been written.
      if (w_acc_fall || r_done_wait) begin
        if (!r_hold_full || (r_state == S_DL_WR)) begin
          r_dl_done   <= 1'b1;
          r_done_wait <= 1'b0;
        end else begin
          r_done_wait <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Directed testbench for atom_mem_arbiter with a behavioural registered-read memory.
module tb_atom_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [17:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_rom;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dl_active;
  logic        dl_done;
  logic [12:0] dl_count;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  atom_mem_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_rom(cpu_rom),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .dl_active(dl_active), .dl_done(dl_done), .dl_count(dl_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory block: registered read, write-first not needed; poke port for preloading.
  logic [7:0]  mem [0:262143];
  logic        poke_en = 1'b0;
  logic [17:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clk_sys) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Event counters sampled on the falling edge.
  int we_count = 0;
  int done_count = 0;
  int wait_seen = 0;
  always @(negedge clk_sys) begin
    if (mem_we) we_count <= we_count + 1;
    if (dl_done) done_count <= done_count + 1;
    if (ioctl_wait) wait_seen <= wait_seen + 1;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  // One CPU access; returns the data and the number of edges until cpu_ready.
  task automatic cpu_access(input logic [17:0] a, input logic we, input logic rom,
                            input logic [7:0] wd, output logic [7:0] rd, output int lat);
    cpu_addr = a; cpu_we = we; cpu_rom = rom; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lat++;
      if (i == 0) begin
        cpu_req = 1'b0; cpu_addr = ~a; cpu_we = ~we; cpu_rom = ~rom; cpu_wdata = ~wd;
        ioctl_wr = 1'b0;
      end
      if (cpu_ready) break;
    end
    rd = cpu_rdata;
  endtask

  // Sends one download byte, honouring ioctl_wait; timeout reports a stall.
  task automatic dl_byte(input int off, input logic [7:0] d, output logic stalled);
    stalled = 1'b0;
    for (int k = 0; k < 20 && ioctl_wait; k++) tick();
    if (ioctl_wait) stalled = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 25'(off); ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int lat, w0;
    logic bad;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_rom = 1'b0;
    cpu_wdata = '0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    poke(18'h0C000, 8'h3A);
    poke(18'h0F000, 8'h11);
    poke(18'h18000, 8'hA5);
    for (int k = 0; k < 9; k++) poke(18'h01000 + 18'(k), 8'h40 + 8'(k));
    w0 = we_count;
    cpu_req = 1'b1; cpu_addr = 18'h0C000; bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({cpu_rdata, cpu_ready, ioctl_wait, dl_active, dl_done, dl_count,
           mem_addr, mem_we, mem_din} !== '0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL reset_outputs: got nonzero output, need all 0");
    else n_pass++;
    n_checks++;
    if (we_count - w0 !== 0) $display("FAIL reset_no_we: got %0d writes, need 0", we_count - w0);
    else n_pass++;
    cpu_req = 1'b0; reset_n = 1'b1;
    tick();
    cpu_access(18'h0C000, 1'b0, 1'b0, 8'h00, rd, lat);
    $display("reset read 0x0C000 -> %02h lat %0d", rd, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL reset_read_lat: got %0d, need 3", lat);
    else n_pass++;
    n_checks++;
    if (rd !== 8'h3A) $display("FAIL reset_read_data: got %02h, need 3a", rd);
    else n_pass++;
  endtask

  task automatic test_write_protect();
    logic [7:0] rd;
    int lat, w0;
    w0 = we_count;
    cpu_access(18'h0F000, 1'b1, 1'b1, 8'h55, rd, lat);
    $display("rom write 0x0F000 lat %0d writes %0d", lat, we_count - w0);
    n_checks++;
    if (lat !== 3 || we_count - w0 !== 0)
      $display("FAIL rom_write: got lat %0d writes %0d, need lat 3 writes 0", lat, we_count - w0);
    else n_pass++;
    cpu_access(18'h0F000, 1'b0, 1'b0, 8'h00, rd, lat);
    $display("read 0x0F000 -> %02h", rd);
    n_checks++;
    if (rd !== 8'h11) $display("FAIL rom_readback: got %02h, need 11", rd);
    else n_pass++;
    w0 = we_count;
    cpu_access(18'h00100, 1'b1, 1'b0, 8'h55, rd, lat);
    $display("ram write 0x00100 lat %0d writes %0d", lat, we_count - w0);
    n_checks++;
    if (lat !== 3 || we_count - w0 !== 1)
      $display("FAIL ram_write: got lat %0d writes %0d, need lat 3 writes 1", lat, we_count - w0);
    else n_pass++;
    cpu_access(18'h00100, 1'b0, 1'b0, 8'h00, rd, lat);
    $display("read 0x00100 -> %02h", rd);
    n_checks++;
    if (rd !== 8'h55) $display("FAIL ram_readback: got %02h, need 55", rd);
    else n_pass++;
  endtask

  task automatic test_download();
    int w0, d0, stalls, errs;
    logic st;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    w0 = we_count; d0 = done_count; stalls = 0; errs = 0;
    tick();
    n_checks++;
    if (dl_active !== 1'b1) $display("FAIL dl_active_rise: got %b, need 1", dl_active);
    else n_pass++;
    for (int n = 0; n <= 4096; n++) begin
      dl_byte(n, (n == 4096) ? 8'hDD : 8'(n), st);
      if (st) stalls++;
    end
    for (int k = 0; k < 4; k++) tick();
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int n = 0; n < 4096; n++)
      if (mem[18'h17000 + 18'(n)] !== 8'(n)) errs++;
    $display("download: count %0d writes %0d done %0d bad bytes %0d",
             dl_count, we_count - w0, done_count - d0, errs);
    n_checks++;
    if (stalls !== 0) $display("FAIL dl_stall: got %0d stalls, need 0", stalls);
    else n_pass++;
    n_checks++;
    if (errs !== 0) $display("FAIL dl_contents: got %0d bad bytes, need 0", errs);
    else n_pass++;
    n_checks++;
    if (mem[18'h18000] !== 8'hA5) $display("FAIL dl_beyond: got %02h, need a5", mem[18'h18000]);
    else n_pass++;
    n_checks++;
    if (dl_count !== 13'd4096) $display("FAIL dl_count: got %0d, need 4096", dl_count);
    else n_pass++;
    n_checks++;
    if (done_count - d0 !== 1) $display("FAIL dl_done: got %0d pulses, need 1", done_count - d0);
    else n_pass++;
    n_checks++;
    if (we_count - w0 !== 4096) $display("FAIL dl_writes: got %0d, need 4096", we_count - w0);
    else n_pass++;
    n_checks++;
    if (dl_active !== 1'b0) $display("FAIL dl_active_fall: got %b, need 0", dl_active);
    else n_pass++;
  endtask

  task automatic test_starvation();
    logic [7:0] rd;
    int lat, w0, d0;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick(); tick();
    d0 = done_count;
    w0 = we_count;
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'hC3;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        n_checks++;
        if (ioctl_wait !== 1'b1 || we_count - w0 !== 0)
          $display("FAIL starve_before: got wait %b writes %0d, need wait 1 writes 0",
                   ioctl_wait, we_count - w0);
        else n_pass++;
      end
      cpu_access(18'h01000 + 18'(k), 1'b0, 1'b0, 8'h00, rd, lat);
      $display("starve access %0d -> %02h lat %0d", k, rd, lat);
      n_checks++;
      if (lat !== ((k == 8) ? 4 : 3) || rd !== 8'h40 + 8'(k))
        $display("FAIL starve_access%0d: got lat %0d data %02h, need lat %0d data %02h",
                 k, lat, rd, (k == 8) ? 4 : 3, 8'h40 + 8'(k));
      else n_pass++;
    end
    n_checks++;
    if (ioctl_wait !== 1'b0 || we_count - w0 !== 1 || mem[18'h17005] !== 8'hC3)
      $display("FAIL starve_drain: got wait %b writes %0d byte %02h, need 0 1 c3",
               ioctl_wait, we_count - w0, mem[18'h17005]);
    else n_pass++;
    ioctl_download = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (dl_count !== 13'd1 || done_count - d0 !== 1)
      $display("FAIL starve_status: got count %0d done %0d, need 1 1", dl_count, done_count - d0);
    else n_pass++;
  endtask

  task automatic test_wrong_index();
    int w0, d0, ws0;
    logic act;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    w0 = we_count; d0 = done_count; ws0 = wait_seen; act = 1'b0;
    for (int n = 0; n < 4; n++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(n); ioctl_dout = 8'hEE;
      tick();
      ioctl_wr = 1'b0;
      if (dl_active) act = 1'b1;
      tick(); tick();
      if (dl_active) act = 1'b1;
    end
    ioctl_download = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    $display("wrong index: writes %0d done %0d wait %0d active %b",
             we_count - w0, done_count - d0, wait_seen - ws0, act);
    n_checks++;
    if (we_count - w0 !== 0 || mem[18'h17001] !== 8'h01)
      $display("FAIL wrong_idx_write: got %0d writes byte %02h, need 0 writes byte 01",
               we_count - w0, mem[18'h17001]);
    else n_pass++;
    n_checks++;
    if (act !== 1'b0 || done_count - d0 !== 0 || wait_seen - ws0 !== 0)
      $display("FAIL wrong_idx_status: got active %b done %0d wait %0d, need 0 0 0",
               act, done_count - d0, wait_seen - ws0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_download();
    int w0, d0;
    logic st, s_any;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    w0 = we_count; d0 = done_count;
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    n_checks++;
    if (ioctl_wait !== 1'b1) $display("FAIL midrst_full: got wait %b, need 1", ioctl_wait);
    else n_pass++;
    reset_n = 1'b0; ioctl_download = 1'b0;
    tick(); tick();
    n_checks++;
    if (ioctl_wait !== 1'b0 || dl_active !== 1'b0)
      $display("FAIL midrst_clear: got wait %b active %b, need 0 0", ioctl_wait, dl_active);
    else n_pass++;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    $display("mid reset: writes %0d done %0d byte %02h", we_count - w0, done_count - d0,
             mem[18'h17010]);
    n_checks++;
    if (we_count - w0 !== 0 || done_count - d0 !== 0 || mem[18'h17010] !== 8'h10)
      $display("FAIL midrst_drop: got writes %0d done %0d byte %02h, need 0 0 10",
               we_count - w0, done_count - d0, mem[18'h17010]);
    else n_pass++;
    d0 = done_count; s_any = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      dl_byte(32 + n, 8'h5A + 8'(n), st);
      if (st) s_any = 1'b1;
    end
    for (int k = 0; k < 4; k++) tick();
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    $display("restart: count %0d done %0d byte %02h", dl_count, done_count - d0, mem[18'h17020]);
    n_checks++;
    if (s_any !== 1'b0 || dl_count !== 13'd3 || done_count - d0 !== 1 || mem[18'h17022] !== 8'h5C)
      $display("FAIL restart: got stall %b count %0d done %0d byte %02h, need 0 3 1 5c",
               s_any, dl_count, done_count - d0, mem[18'h17022]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_protect();
    test_download();
    test_starvation();
    test_wrong_index();
    test_reset_mid_download();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
